axi4lite_reg_slice: RTL

// - Fully registered AXI4-Lite pipeline stage between the picorv32_axi master port and the axi4_memory slave.
// - Breaks every combinational valid/ready/payload path so the core-to-memory interface closes timing.
// - Five independent 2-entry skid buffers (AW, W, B, AR, R); full throughput, 1-cycle forward latency.
// - Protocol-transparent: no reordering, no beat dropped or duplicated.

---
 rtl/axi4lite_pkg.sv | 21 ++
 rtl/axi_skid_buffer.sv | 96 +++++++++
 rtl/axi4lite_reg_slice.sv | 125 ++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite slice definitions: default widths, per-channel payload widths
// and the skid buffer occupancy encoding.
package axi4lite_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;

    localparam int AW_PL_W = ADDR_W + 3;
    localparam int W_PL_W  = DATA_W + STRB_W;
    localparam int AR_PL_W = ADDR_W + 3;
    localparam int R_PL_W  = DATA_W;
    localparam int B_PL_W  = 1;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry valid/ready skid buffer with fully registered outputs; with ENABLE=0
// it collapses to a zero-latency wire-through.
module axi_skid_buffer
    import axi4lite_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (ENABLE) begin : g_slice
            skid_state_t      state_reg, state_next;
            logic             in_ready_reg, in_ready_next;
            logic             out_valid_reg, out_valid_next;
            logic [WIDTH-1:0] data_reg, data_next;
            logic [WIDTH-1:0] skid_reg, skid_next;
            logic             push, pop;

            // Handshakes are judged on the registered flags so no ready path crosses the slice.
            assign push = in_valid & in_ready_reg;
            assign pop  = out_valid_reg & out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg     <= SKID_EMPTY;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    data_reg      <= '0;
                    skid_reg      <= '0;
                end else begin
                    state_reg     <= state_next;
                    in_ready_reg  <= in_ready_next;
                    out_valid_reg <= out_valid_next;
                    data_reg      <= data_next;
                    skid_reg      <= skid_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                data_next  = data_reg;
                skid_next  = skid_reg;
                case (state_reg)
                    SKID_EMPTY: begin
                        if (push) begin
                            state_next = SKID_ONE;
                            data_next  = in_data;
                        end
                    end
                    SKID_ONE: begin
                        if (push && pop) begin
                            data_next = in_data;
                        end else if (pop) begin
                            state_next = SKID_EMPTY;
                        end else if (push) begin
                            state_next = SKID_FULL;
                            skid_next  = in_data;
                        end
                    end
                    SKID_FULL: begin
                        if (pop) begin
                            state_next = SKID_ONE;
                            data_next  = skid_reg;
                        end
                    end
                    default: begin
                        state_next = SKID_EMPTY;
                    end
                endcase
                in_ready_next  = (state_next != SKID_FULL);
                out_valid_next = (state_next != SKID_EMPTY);
            end

            assign in_ready  = in_ready_reg;
            assign out_valid = out_valid_reg;
            assign out_data  = data_reg;
        end else begin : g_wire
            logic unused_clk_reset;

            assign out_valid        = in_valid;
            assign out_data         = in_data;
            assign in_ready         = out_ready;
            assign unused_clk_reset = clk ^ reset;
        end
    endgenerate

endmodule

// File: rtl/axi4lite_reg_slice.sv
// AXI4-Lite register slice between core master and memory slave: one skid buffer
// per channel, selected per channel by SLICE_MASK {R,AR,B,W,AW}.
module axi4lite_reg_slice
    import axi4lite_pkg::*;
#(
    parameter int         ADDR_W     = axi4lite_pkg::ADDR_W,
    parameter int         DATA_W     = axi4lite_pkg::DATA_W,
    parameter logic [4:0] SLICE_MASK = 5'b11111
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  s_axi_awvalid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    output logic                  s_axi_awready,
    output logic                  m_axi_awvalid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    input  logic                  m_axi_awready,

    input  logic                  s_axi_wvalid,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    output logic                  s_axi_wready,
    output logic                  m_axi_wvalid,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    input  logic                  m_axi_wready,

    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic                  s_axi_arvalid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_arready,
    output logic                  m_axi_arvalid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    input  logic                  m_axi_arready,

    input  logic                  m_axi_rvalid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    output logic                  m_axi_rready,
    output logic                  s_axi_rvalid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    input  logic                  s_axi_rready
);

    localparam int STRB_LW = DATA_W / 8;
    localparam int AW_LW   = ADDR_W + 3;
    localparam int W_LW    = DATA_W + STRB_LW;
    localparam int AR_LW   = ADDR_W + 3;
    localparam int R_LW    = DATA_W;

    logic [AW_LW-1:0]  aw_out;
    logic [W_LW-1:0]   w_out;
    logic [AR_LW-1:0]  ar_out;
    logic [R_LW-1:0]   r_out;
    logic [B_PL_W-1:0] unused_b_data;

    axi_skid_buffer #(.WIDTH(AW_LW), .ENABLE(SLICE_MASK[0])) u_aw (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_axi_awvalid),
        .in_ready  (s_axi_awready),
        .in_data   ({s_axi_awprot, s_axi_awaddr}),
        .out_valid (m_axi_awvalid),
        .out_ready (m_axi_awready),
        .out_data  (aw_out)
    );
    assign {m_axi_awprot, m_axi_awaddr} = aw_out;

    axi_skid_buffer #(.WIDTH(W_LW), .ENABLE(SLICE_MASK[1])) u_w (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_axi_wvalid),
        .in_ready  (s_axi_wready),
        .in_data   ({s_axi_wstrb, s_axi_wdata}),
        .out_valid (m_axi_wvalid),
        .out_ready (m_axi_wready),
        .out_data  (w_out)
    );
    assign {m_axi_wstrb, m_axi_wdata} = w_out;

    // Write response has no payload in AXI4-Lite here; a constant bit keeps the buffer uniform.
    axi_skid_buffer #(.WIDTH(B_PL_W), .ENABLE(SLICE_MASK[2])) u_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (m_axi_bvalid),
        .in_ready  (m_axi_bready),
        .in_data   (1'b0),
        .out_valid (s_axi_bvalid),
        .out_ready (s_axi_bready),
        .out_data  (unused_b_data)
    );

    axi_skid_buffer #(.WIDTH(AR_LW), .ENABLE(SLICE_MASK[3])) u_ar (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_axi_arvalid),
        .in_ready  (s_axi_arready),
        .in_data   ({s_axi_arprot, s_axi_araddr}),
        .out_valid (m_axi_arvalid),
        .out_ready (m_axi_arready),
        .out_data  (ar_out)
    );
    assign {m_axi_arprot, m_axi_araddr} = ar_out;

    axi_skid_buffer #(.WIDTH(R_LW), .ENABLE(SLICE_MASK[4])) u_r (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (m_axi_rvalid),
        .in_ready  (m_axi_rready),
        .in_data   (m_axi_rdata),
        .out_valid (s_axi_rvalid),
        .out_ready (s_axi_rready),
        .out_data  (r_out)
    );
    assign s_axi_rdata = r_out;

endmodule
